// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter pipeline.
// Sizing defaults match the 64-bit core with 4-byte instructions.
package pc_pkg;

  localparam int PC_WIDTH = 64;
  localparam int PC_INC   = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

  typedef struct packed {
    pc_t  pc;
    logic valid;
  } stage_entry_t;

  // Returns a mask covering the address bits below the instruction alignment.
  function automatic pc_t align_mask(input int inc);
    return pc_t'(inc - 1);
  endfunction

endpackage

// File: rtl/pc_pipe_if.sv
// Control and observation bundle between next-PC logic and the PC pipeline.
// The master side drives stall/redirect; the slave side is pc_pipe.
interface pc_pipe_if #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 3
);

  logic                      stall;
  logic                      redirect_valid;
  logic [WIDTH-1:0]          redirect_target;
  logic [WIDTH-1:0]          pc_out;
  logic [STAGES*WIDTH-1:0]   stage_pc;
  logic [STAGES-1:0]         stage_valid;
  logic                      misalign;

  modport master (
    output stall,
    output redirect_valid,
    output redirect_target,
    input  pc_out,
    input  stage_pc,
    input  stage_valid,
    input  misalign
  );

  modport slave (
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    output pc_out,
    output stage_pc,
    output stage_valid,
    output misalign
  );

endinterface

// File: rtl/pc_stage_reg.sv
// Generic register with hold enable, synchronous clear and active-low reset.
// Priority: reset > clear > enable.
module pc_stage_reg #(
  parameter int             W       = 65,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_reg <= RST_VAL;
    end else if (clr) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pc_pipe.sv
// Fetch PC register plus a chain of per-stage PC/valid copies with stall
// hold, bubble insertion, redirect kill and a sticky misaligned-target flag.
module pc_pipe
  import pc_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH,
  parameter int               INC       = PC_INC,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               STAGES    = 3,
  parameter int               HOLD      = 1,
  parameter int               KILL      = 1
) (
  input  logic       clk,
  input  logic       reset,
  pc_pipe_if.slave   bus
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic             pc_en;
  logic             misalign_reg;
  logic             misalign_next;

  // Each stage entry is {valid, pc}; bubbles are all-zero.
  logic [STAGES-1:0][WIDTH:0] stage_q;

  always_comb begin
    pc_next = pc_reg + INC_W;
    pc_en   = !bus.stall;
    if (bus.redirect_valid) begin
      pc_next = bus.redirect_target & ~ALIGN_MASK;
      pc_en   = 1'b1;
    end
  end

  pc_stage_reg #(
    .W       (WIDTH),
    .RST_VAL (RESET_VEC)
  ) u_fetch_pc (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .clr   (1'b0),
    .d     (pc_next),
    .q     (pc_reg)
  );

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam bit IN_KILL = (gi < KILL);
      localparam bit IN_HOLD = (gi < HOLD);
      localparam bit IS_GAP  = (gi == HOLD);

      logic [WIDTH:0] shift_in;
      logic           en;
      logic           clr;

      if (gi == 0) begin : g_head
        assign shift_in = {1'b1, pc_reg};
      end else begin : g_tail
        assign shift_in = stage_q[gi-1];
      end

      // Redirect beats stall: killed stages bubble, the rest keep shifting.
      always_comb begin
        en  = 1'b1;
        clr = 1'b0;
        if (bus.redirect_valid) begin
          clr = IN_KILL;
        end else if (bus.stall) begin
          en  = !IN_HOLD;
          clr = IS_GAP;
        end
      end

      pc_stage_reg #(
        .W       (WIDTH + 1),
        .RST_VAL ('0)
      ) u_stage (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (clr),
        .d     (shift_in),
        .q     (stage_q[gi])
      );

      assign bus.stage_pc[gi*WIDTH +: WIDTH] = stage_q[gi][WIDTH-1:0];
      assign bus.stage_valid[gi]             = stage_q[gi][WIDTH];
    end
  endgenerate

  always_comb begin
    misalign_next = misalign_reg;
    if (bus.redirect_valid && |(bus.redirect_target & ALIGN_MASK)) begin
      misalign_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= misalign_next;
    end
  end

  assign bus.pc_out   = pc_reg;
  assign bus.misalign = misalign_reg;

endmodule

// File: tb/tb_pc_pipe.sv
// Directed bench for pc_pipe: a reference model pushes expected state per
// cycle into a scoreboard queue, popped and compared after each edge.
module tb_pc_pipe;
  import pc_pkg::*;

  localparam int W = 64;
  localparam int S = 3;

  typedef struct {
    logic [W-1:0]   pc;
    logic [S*W-1:0] spc;
    logic [S-1:0]   sv;
    logic           mis;
  } exp_t;

  logic clk;
  logic reset;

  pc_pipe_if #(.WIDTH(W), .STAGES(S)) bus ();

  pc_pipe #(
    .WIDTH     (W),
    .INC       (4),
    .RESET_VEC ('0),
    .STAGES    (S),
    .HOLD      (1),
    .KILL      (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int failed;
  exp_t sb[$];

  logic [W-1:0] m_pc;
  logic [W-1:0] m_spc [S];
  logic         m_sv  [S];
  logic         m_mis;

  task automatic chk(input string tag, input logic [S*W-1:0] obs, input logic [S*W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge, written from the block description.
  task automatic model_edge(input logic rst_n, input logic st, input logic rv, input logic [W-1:0] tgt);
    logic [W-1:0] old_pc;
    logic [W-1:0] old_spc [S];
    logic         old_sv  [S];
    old_pc = m_pc;
    for (int k = 0; k < S; k++) begin
      old_spc[k] = m_spc[k];
      old_sv[k]  = m_sv[k];
    end
    if (!rst_n) begin
      m_pc  = '0;
      m_mis = 1'b0;
      for (int k = 0; k < S; k++) begin
        m_spc[k] = '0;
        m_sv[k]  = 1'b0;
      end
    end else if (rv) begin
      m_pc = {tgt[W-1:2], 2'b00};
      if (tgt[1:0] != 2'b00) m_mis = 1'b1;
      m_spc[0] = '0;
      m_sv[0]  = 1'b0;
      for (int k = 1; k < S; k++) begin
        m_spc[k] = old_spc[k-1];
        m_sv[k]  = old_sv[k-1];
      end
    end else if (st) begin
      m_spc[1] = '0;
      m_sv[1]  = 1'b0;
      for (int k = 2; k < S; k++) begin
        m_spc[k] = old_spc[k-1];
        m_sv[k]  = old_sv[k-1];
      end
    end else begin
      m_pc     = old_pc + 64'd4;
      m_spc[0] = old_pc;
      m_sv[0]  = 1'b1;
      for (int k = 1; k < S; k++) begin
        m_spc[k] = old_spc[k-1];
        m_sv[k]  = old_sv[k-1];
      end
    end
  endtask

  task automatic step(input string tag, input logic rst_n, input logic st, input logic rv, input logic [W-1:0] tgt);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset               = rst_n;
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    model_edge(rst_n, st, rv, tgt);
    e.pc  = m_pc;
    e.mis = m_mis;
    for (int k = 0; k < S; k++) begin
      e.spc[k*W +: W] = m_spc[k];
      e.sv[k]         = m_sv[k];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".pc_out"},      {128'd0, bus.pc_out},      {128'd0, got.pc});
    chk({tag, ".stage_pc"},    bus.stage_pc,              got.spc);
    chk({tag, ".stage_valid"}, {189'd0, bus.stage_valid}, {189'd0, got.sv});
    chk({tag, ".misalign"},    {191'd0, bus.misalign},    {191'd0, got.mis});
    $display("[TB] %s pc_out=%0h stage_pc=%0h valid=%b misalign=%b",
             tag, bus.pc_out, bus.stage_pc, bus.stage_valid, bus.misalign);
  endtask

  function automatic logic [S*W-1:0] flat(input logic [W-1:0] s2, input logic [W-1:0] s1, input logic [W-1:0] s0);
    return {s2, s1, s0};
  endfunction

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    m_pc  = '0;
    m_mis = 1'b0;
    for (int k = 0; k < S; k++) begin
      m_spc[k] = '0;
      m_sv[k]  = 1'b0;
    end

    // Reset then three free-running cycles
    step("rst0", 1'b0, 1'b0, 1'b0, '0);
    step("rst1", 1'b0, 1'b0, 1'b0, '0);
    chk("reset.state", {bus.misalign, bus.stage_valid, bus.pc_out, bus.stage_pc[127:0]}, '0);
    for (int i = 0; i < 3; i++) step("adv", 1'b1, 1'b0, 1'b0, '0);
    chk("t1.pc",    {128'd0, bus.pc_out}, {128'd0, 64'hC});
    chk("t1.stage", bus.stage_pc, flat(64'h0, 64'h4, 64'h8));
    chk("t1.valid", {189'd0, bus.stage_valid}, {189'd0, 3'b111});

    // Stall bubble insertion
    step("adv", 1'b1, 1'b0, 1'b0, '0);
    step("stall", 1'b1, 1'b1, 1'b0, '0);
    chk("t2.pc",    {128'd0, bus.pc_out}, {128'd0, 64'h10});
    chk("t2.stage", bus.stage_pc, flat(64'h8, 64'h0, 64'hC));
    chk("t2.valid", {189'd0, bus.stage_valid}, {189'd0, 3'b101});
    step("release", 1'b1, 1'b0, 1'b0, '0);
    chk("t2.rel", {64'd0, bus.stage_pc[W-1:0], bus.pc_out}, {64'd0, 64'h10, 64'h14});

    // Redirect with wrong-path kill
    for (int i = 0; i < 3; i++) step("adv", 1'b1, 1'b0, 1'b0, '0);
    chk("t3.pre", {64'd0, bus.stage_pc[W-1:0], bus.pc_out}, {64'd0, 64'h1C, 64'h20});
    step("redir", 1'b1, 1'b0, 1'b1, 64'h400);
    chk("t3.pc",    {128'd0, bus.pc_out}, {128'd0, 64'h400});
    chk("t3.stage", {bus.stage_valid[1:0], bus.stage_pc[2*W-1:0]}, {2'b10, 64'h1C, 64'h0});
    step("after", 1'b1, 1'b0, 1'b0, '0);
    chk("t3.next", {63'd0, bus.stage_valid[0], bus.stage_pc[W-1:0], bus.pc_out}, {63'd0, 1'b1, 64'h400, 64'h404});

    // Redirect overrides stall
    step("st_redir", 1'b1, 1'b1, 1'b1, 64'h800);
    chk("t4", {62'd0, bus.misalign, bus.stage_valid[0], bus.stage_pc[W-1:0], bus.pc_out},
        {62'd0, 1'b0, 1'b0, 64'h0, 64'h800});

    // Misaligned target and wrap-around
    step("misal", 1'b1, 1'b0, 1'b1, 64'h402);
    chk("t5.pc", {127'd0, bus.misalign, bus.pc_out}, {127'd0, 1'b1, 64'h400});
    for (int i = 0; i < 5; i++) step("sticky", 1'b1, 1'b0, 1'b0, '0);
    chk("t5.sticky", {191'd0, bus.misalign}, {191'd0, 1'b1});
    step("top", 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step("wrap", 1'b1, 1'b0, 1'b0, '0);
    chk("t5.wrap", {64'd0, bus.stage_pc[W-1:0], bus.pc_out}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0});

    // Reset during stall with misalign set
    step("stall", 1'b1, 1'b1, 1'b0, '0);
    step("stall", 1'b1, 1'b1, 1'b0, '0);
    step("rst_st", 1'b0, 1'b1, 1'b1, 64'h123);
    chk("t6.state", {bus.misalign, bus.stage_valid, bus.pc_out, bus.stage_pc[127:0]}, '0);
    chk("t6.s2", {128'd0, bus.stage_pc[3*W-1:2*W]}, '0);
    step("resume", 1'b1, 1'b0, 1'b0, '0);
    chk("t6.resume", {127'd0, bus.stage_valid[0], bus.pc_out}, {127'd0, 1'b1, 64'h4});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_pipe.md
Name: pc_pipe

Overview:
Parametrised program-counter unit for the pipelined CPU: the fetch PC register plus a shift chain of per-stage PC/valid copies, so downstream stages (decode, execute, ...) receive the PC of the instruction they hold. It adds capabilities the plain PC register lacks: auto-increment, stall hold with bubble insertion, branch redirect with wrong-path kill, a reset vector, and a sticky misaligned-target flag. It sits between the next-PC logic and the instruction memory / pipeline registers.

Parameters:
WIDTH, 64, PC width in bits
INC, 4, sequential increment; power of two
RESET_VEC, 0, fetch PC loaded by reset; must be INC-aligned
STAGES, 3, number of downstream PC/valid copies (stage 0 = decode)
HOLD, 1, stages 0..HOLD-1 hold on stall; 1 <= HOLD < STAGES
KILL, 1, stages 0..KILL-1 invalidated on redirect; 1 <= KILL <= STAGES

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-low reset (asserted when 0)
stall  input  1  hold fetch PC and stages 0..HOLD-1 this cycle
redirect_valid  input  1  load redirect_target as next fetch PC
redirect_target  input  WIDTH  branch/jump target
pc_out  output  WIDTH  current fetch PC
stage_pc  output  STAGES*WIDTH  flattened per-stage PCs, stage k in bits [k*WIDTH +: WIDTH]
stage_valid  output  STAGES  per-stage valid bits
misalign  output  1  sticky: a redirect target was not INC-aligned

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Priority at each posedge: reset low > redirect_valid > stall > normal advance.
- Reset (reset==0 at posedge): pc_out=RESET_VEC; all stage_pc=0; stage_valid=0; misalign=0. Applies mid-stall or mid-redirect; other inputs are ignored that cycle.
- Normal advance: pc_out <= pc_out+INC, modulo 2^WIDTH (0x...FFFC+4 -> 0). stage 0 <= {pc_out, valid=1}; stage k <= stage k-1 for k>=1.
- Stall, no redirect: pc_out and stages 0..HOLD-1 hold. Stage HOLD <= bubble {pc=0, valid=0}. Stages above HOLD shift normally.
- Redirect (overrides stall): pc_out <= redirect_target with low log2(INC) bits cleared. Stages 0..KILL-1 <= bubble. Stages KILL..STAGES-1 <= previous stage contents (shift).
- Misalign: if redirect_valid and any of redirect_target[log2(INC)-1:0] is 1, set misalign=1. It stays 1 until reset.
- Bubbles always carry pc=0, so verification can compare stage_pc exactly.
- Latency: a redirect is visible on pc_out one cycle later. The redirected PC reaches stage 0 one cycle after that, unless stalled.

Decomposition:
- Shared package pc_pkg: localparams PC_WIDTH=64 and PC_INC=4, typedef pc_t (logic [PC_WIDTH-1:0]), typedef stage_entry_t (struct: pc_t pc; logic valid).
- One natural sub-module, pc_stage_reg: a WIDTH+1-bit register with enable (hold), synchronous clear-to-bubble, and active-low synchronous reset. It is instantiated STAGES times in a generate loop; the fetch PC register is a separate instance without a valid bit.

Test Plan:
Defaults used in every scenario: WIDTH=64, INC=4, RESET_VEC=0, STAGES=3, HOLD=1, KILL=1.
1. reset=0 for 2 cycles, then reset=1 for 3 cycles -> pc_out=0xC; stage_pc={2:0x0, 1:0x4, 0:0x8}; stage_valid=3'b111.
2. With pc_out=0x10, stage0=0xC, stage1=0x8: stall=1 for one cycle -> pc_out=0x10; stage0=0xC valid; stage1 pc=0 valid=0; stage2=0x8 valid. On release, pc_out=0x14 and stage0=0x10.
3. At pc_out=0x20, stage0=0x1C: redirect_valid=1, target=0x400 -> pc_out=0x400; stage0 bubble; stage1=0x1C. Next cycle -> pc_out=0x404, stage0=0x400 valid.
4. stall=1 and redirect_valid=1 together with target=0x800 -> identical to a pure redirect: pc_out=0x800, stage0 bubble, misalign=0.
5. redirect target=0x402 -> pc_out=0x400; misalign=1 and stays 1 for 5 further cycles. Target 0xFFFF_FFFF_FFFF_FFFC -> next pc_out wraps to 0x0.
6. Assert reset=0 during an active stall, with misalign=1 -> next edge: pc_out=RESET_VEC, all stage_valid=0, all stage_pc=0, misalign=0.
